// File: rtl/approx_mac_acc.sv
// Streaming signed accumulator for approximate multiplier products, emitting per-vector sums.
// Define APPROX_MAC_SAT_EN to saturate on overflow instead of wrapping modulo 2^ACC_W.
module approx_mac_acc #(
   parameter int ACC_W     = 40,
   parameter int MAX_TERMS = 256,
   parameter int CNT_W     = $clog2(MAX_TERMS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf
);

   typedef enum logic {EMPTY, ACCUM} state_t;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);
`ifdef APPROX_MAC_SAT_EN
   localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

   state_t           state, state_n;
   logic [ACC_W-1:0] acc, acc_n;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic             ovf, ovf_d;

   logic             accept;
   logic             flush;
   logic [ACC_W-1:0] base;
   logic [ACC_W:0]   sum_wide;
   logic [ACC_W-1:0] sum_res;
   logic             ovf_beat;
   logic [CNT_W-1:0] cnt_n;
   logic             ovf_n;

   assign in_ready = ~out_valid | out_ready;
   assign accept   = in_valid & in_ready;

   // One extra bit of headroom lets the top two bits reveal a signed overflow.
   always_comb begin
      base     = (state == EMPTY) ? '0 : acc;
      sum_wide = {base[ACC_W-1], base} + {{(ACC_W-31){in_data[31]}}, in_data};
      ovf_beat = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
      cnt_n    = ((state == EMPTY) ? '0 : cnt) + CNT_W'(1);
      ovf_n    = ((state == EMPTY) ? 1'b0 : ovf) | ovf_beat;
      flush    = accept & (in_last | (cnt_n == MAX_CNT));
      sum_res  = sum_wide[ACC_W-1:0];
`ifdef APPROX_MAC_SAT_EN
      if (ovf_beat) begin
         sum_res = sum_wide[ACC_W] ? SAT_MIN : SAT_MAX;
      end
`endif
   end

   always_comb begin
      state_n = state;
      acc_n   = acc;
      cnt_d   = cnt;
      ovf_d   = ovf;
      if (flush) begin
         state_n = EMPTY;
         acc_n   = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
      end else if (accept) begin
         state_n = ACCUM;
         acc_n   = sum_res;
         cnt_d   = cnt_n;
         ovf_d   = ovf_n;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= EMPTY;
         acc   <= '0;
         cnt   <= '0;
         ovf   <= 1'b0;
      end else begin
         state <= state_n;
         acc   <= acc_n;
         cnt   <= cnt_d;
         ovf   <= ovf_d;
      end
   end

   // A flush in the same cycle as a consume overwrites the old result, so out_valid never bubbles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_count <= '0;
         out_ovf   <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b1;
         out_sum   <= sum_res;
         out_count <= cnt_n;
         out_ovf   <= ovf_n;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_approx_mac_acc.sv
// Directed and scoreboard testbench for approx_mac_acc (default, ACC_W=33 and MAX_TERMS=1 instances).
module tb_approx_mac_acc;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic        in_valid, in_ready, in_last, out_valid, out_ready, out_ovf;
   logic [31:0] in_data;
   logic [39:0] out_sum;
   logic [8:0]  out_count;

   logic        b_valid, b_last, b_out_ready;
   logic [31:0] b_data;
   logic        b1_ready, b1_valid, b1_ovf;
   logic [32:0] b1_sum;
   logic [8:0]  b1_count;
   logic        b2_ready, b2_valid, b2_ovf;
   logic [39:0] b2_sum;
   logic [0:0]  b2_count;

   approx_mac_acc u0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_count(out_count), .out_ovf(out_ovf));

   approx_mac_acc #(.ACC_W(33)) u1 (
      .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b1_ready), .in_data(b_data),
      .in_last(b_last), .out_valid(b1_valid), .out_ready(b_out_ready), .out_sum(b1_sum),
      .out_count(b1_count), .out_ovf(b1_ovf));

   approx_mac_acc #(.MAX_TERMS(1)) u2 (
      .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b2_ready), .in_data(b_data),
      .in_last(b_last), .out_valid(b2_valid), .out_ready(b_out_ready), .out_sum(b2_sum),
      .out_count(b2_count), .out_ovf(b2_ovf));

   task automatic beat_a(input logic [31:0] d, input logic l);
      in_valid = 1'b1; in_data = d; in_last = l;
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic beat_b(input logic [31:0] d, input logic l);
      b_valid = 1'b1; b_data = d; b_last = l;
      @(posedge clk); #1;
      b_valid = 1'b0; b_last = 1'b0;
   endtask

   task automatic test_reset;
      #12;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (out_sum !== 40'd0) begin errors++; $display("[TB] FAIL reset_out_sum got %h want 0", out_sum); end
      checks++; if (out_count !== 9'd0) begin errors++; $display("[TB] FAIL reset_out_count got %0d want 0", out_count); end
      checks++; if (out_ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_ovf got %b want 0", out_ovf); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
      checks++; if (b1_valid !== 1'b0 || b1_sum !== 33'd0) begin errors++; $display("[TB] FAIL reset_b1 got %b/%h want 0/0", b1_valid, b1_sum); end
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic;
      out_ready = 1'b1;
      beat_a(32'd100, 1'b0);
      beat_a(-32'sd30, 1'b0);
      beat_a(32'd7, 1'b0);
      beat_a(32'd23, 1'b1);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid got %b want 1", out_valid); end
      checks++; if (out_sum !== 40'd100) begin errors++; $display("[TB] FAIL basic_sum got %h want %h", out_sum, 40'd100); end
      checks++; if (out_count !== 9'd4) begin errors++; $display("[TB] FAIL basic_count got %0d want 4", out_count); end
      checks++; if (out_ovf !== 1'b0) begin errors++; $display("[TB] FAIL basic_ovf got %b want 0", out_ovf); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_consumed got %b want 0", out_valid); end
   endtask

   task automatic test_max_terms;
      out_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         beat_a(32'd1, (i == 299));
         if (i == 255) begin
            checks++; if (out_valid !== 1'b1 || out_sum !== 40'd256 || out_count !== 9'd256)
               begin errors++; $display("[TB] FAIL max_first got v%b %0d/%0d want v1 256/256", out_valid, out_sum, out_count); end
         end
         if (i == 256) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL max_gap got %b want 0", out_valid); end
         end
      end
      checks++; if (out_valid !== 1'b1 || out_sum !== 40'd44 || out_count !== 9'd44)
         begin errors++; $display("[TB] FAIL max_second got v%b %0d/%0d want v1 44/44", out_valid, out_sum, out_count); end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure;
      out_ready = 1'b0;
      beat_a(32'd11, 1'b1);
      checks++; if (out_valid !== 1'b1 || out_sum !== 40'd11) begin errors++; $display("[TB] FAIL bp_first got v%b %h want v1 11", out_valid, out_sum); end
      in_valid = 1'b1; in_data = 32'hFFFF_FFFB; in_last = 1'b1;
      repeat (5) begin
         #1;
         checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready got %b want 0", in_ready); end
         checks++; if (out_valid !== 1'b1 || out_sum !== 40'd11 || out_count !== 9'd1)
            begin errors++; $display("[TB] FAIL bp_hold got v%b %h/%0d want v1 11/1", out_valid, out_sum, out_count); end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release got %b want 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_sum !== 40'hFF_FFFF_FFFB || out_count !== 9'd1)
         begin errors++; $display("[TB] FAIL bp_no_bubble got v%b %h/%0d want v1 fffffffffb/1", out_valid, out_sum, out_count); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_drain got %b want 0", out_valid); end
   endtask

   task automatic test_overflow;
      logic [32:0] exp_pos, exp_sticky, exp_neg;
`ifdef APPROX_MAC_SAT_EN
      exp_pos = 33'h0_FFFF_FFFF; exp_sticky = 33'h0_FFFF_FFFE; exp_neg = 33'h1_0000_0000;
`else
      exp_pos = 33'h1_7FFF_FFFD; exp_sticky = 33'h1_7FFF_FFFC; exp_neg = 33'h0_8000_0000;
`endif
      b_out_ready = 1'b1;
      repeat (2) beat_b(32'h7FFF_FFFF, 1'b0);
      beat_b(32'h7FFF_FFFF, 1'b1);
      checks++; if (b1_ovf !== 1'b1 || b1_count !== 9'd3) begin errors++; $display("[TB] FAIL ovf_pos_flag got %b/%0d want 1/3", b1_ovf, b1_count); end
      checks++; if (b1_sum !== exp_pos) begin errors++; $display("[TB] FAIL ovf_pos_sum got %h want %h", b1_sum, exp_pos); end
      repeat (3) beat_b(32'h7FFF_FFFF, 1'b0);
      beat_b(32'hFFFF_FFFF, 1'b1);
      checks++; if (b1_ovf !== 1'b1 || b1_count !== 9'd4) begin errors++; $display("[TB] FAIL ovf_sticky_flag got %b/%0d want 1/4", b1_ovf, b1_count); end
      checks++; if (b1_sum !== exp_sticky) begin errors++; $display("[TB] FAIL ovf_sticky_sum got %h want %h", b1_sum, exp_sticky); end
      repeat (2) beat_b(32'h8000_0000, 1'b0);
      beat_b(32'h8000_0000, 1'b1);
      checks++; if (b1_ovf !== 1'b1 || b1_sum !== exp_neg) begin errors++; $display("[TB] FAIL ovf_neg got %b/%h want 1/%h", b1_ovf, b1_sum, exp_neg); end
      beat_b(32'd5, 1'b1);
      checks++; if (b1_ovf !== 1'b0 || b1_sum !== 33'd5 || b1_count !== 9'd1)
         begin errors++; $display("[TB] FAIL ovf_clear got %b/%h/%0d want 0/5/1", b1_ovf, b1_sum, b1_count); end
   endtask

   task automatic test_max1;
      b_out_ready = 1'b1;
      beat_b(32'd3, 1'b0);
      checks++; if (b2_valid !== 1'b1 || b2_sum !== 40'd3 || b2_count !== 1'b1)
         begin errors++; $display("[TB] FAIL max1_first got v%b %h/%0d want v1 3/1", b2_valid, b2_sum, b2_count); end
      beat_b(32'd4, 1'b0);
      checks++; if (b2_valid !== 1'b1 || b2_sum !== 40'd4 || b2_count !== 1'b1)
         begin errors++; $display("[TB] FAIL max1_second got v%b %h/%0d want v1 4/1", b2_valid, b2_sum, b2_count); end
   endtask

   task automatic test_reset_mid;
      out_ready = 1'b0;
      beat_a(32'd4, 1'b1);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL rmid_pending got %b want 1", out_valid); end
      #2 rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0 || out_sum !== 40'd0 || out_count !== 9'd0 || out_ovf !== 1'b0)
         begin errors++; $display("[TB] FAIL rmid_hold_clear got v%b %h/%0d/%b want all 0", out_valid, out_sum, out_count, out_ovf); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rmid_in_ready got %b want 1", in_ready); end
      rst = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      beat_a(32'd5, 1'b0);
      beat_a(32'd6, 1'b0);
      #2 rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_vec_clear got %b want 0", out_valid); end
      rst = 1'b0;
      @(posedge clk); #1;
      beat_a(32'd9, 1'b1);
      checks++; if (out_valid !== 1'b1 || out_sum !== 40'd9 || out_count !== 9'd1)
         begin errors++; $display("[TB] FAIL rmid_restart got v%b %h/%0d want v1 9/1", out_valid, out_sum, out_count); end
      @(posedge clk); #1;
   endtask

   task automatic test_random;
      longint q_sum[$];
      int     q_cnt[$];
      longint m_acc = 0;
      int     m_cnt = 0;
      int     accepted = 0;
      int     cyc = 0;
      int     d;
      while (accepted < 10000 && cyc < 60000) begin
         d = int'($urandom_range(0, 2000)) - 1000;
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = d;
         in_last   = (accepted == 9999) || ($urandom_range(0, 7) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         checks++; if (in_ready !== (~out_valid | out_ready)) begin errors++; $display("[TB] FAIL rand_in_ready got %b at cycle %0d", in_ready, cyc); end
         if (out_valid && out_ready) begin
            checks++;
            if (q_sum.size() == 0) begin
               errors++; $display("[TB] FAIL rand_dup got result %h want none", out_sum);
            end else begin
               if (out_sum !== 40'(q_sum[0]) || out_count !== 9'(q_cnt[0]) || out_ovf !== 1'b0) begin
                  errors++; $display("[TB] FAIL rand_result got %h/%0d want %h/%0d", out_sum, out_count, 40'(q_sum[0]), q_cnt[0]);
               end
               void'(q_sum.pop_front()); void'(q_cnt.pop_front());
            end
         end
         if (in_valid && in_ready) begin
            m_acc += longint'(d); m_cnt++; accepted++;
            if (in_last || m_cnt == 256) begin
               q_sum.push_back(m_acc); q_cnt.push_back(m_cnt);
               m_acc = 0; m_cnt = 0;
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      checks++; if (accepted < 10000) begin errors++; $display("[TB] FAIL rand_timeout got %0d beats want 10000", accepted); end
      in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
      repeat (4) begin
         #1;
         if (out_valid) begin
            checks++;
            if (q_sum.size() == 0) begin
               errors++; $display("[TB] FAIL rand_drain_dup got result %h want none", out_sum);
            end else begin
               if (out_sum !== 40'(q_sum[0]) || out_count !== 9'(q_cnt[0])) begin
                  errors++; $display("[TB] FAIL rand_drain got %h/%0d want %h/%0d", out_sum, out_count, 40'(q_sum[0]), q_cnt[0]);
               end
               void'(q_sum.pop_front()); void'(q_cnt.pop_front());
            end
         end
         @(posedge clk); #1;
      end
      checks++; if (q_sum.size() != 0 || m_cnt != 0) begin errors++; $display("[TB] FAIL rand_lost got %0d pending want 0", q_sum.size()); end
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
      b_valid = 1'b0; b_data = '0; b_last = 1'b0; b_out_ready = 1'b1;
      test_reset;
      test_basic;
      test_max_terms;
      test_backpressure;
      test_overflow;
      test_max1;
      test_reset_mid;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
